// File: rtl/arcade_pkg.sv
// Shared types and download-index constants for the arcade ROM loader.
package arcade_pkg;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_DSW = 8'd254;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } loader_state_t;

endpackage

// File: rtl/arcade_rom_loader_hold_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module hold_timer #(
  parameter int W = 4
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_r;

  // Count register: load on start, otherwise decrement until it reaches zero.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      count_r <= '0;
    end else if (start) begin
      count_r <= load_val;
    end else if (count_r != '0) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == '0);

endmodule

// File: rtl/arcade_rom_loader.sv
// Filters the hps_io download stream into ROM writes and DIP banks, and
// holds the core in reset while a ROM image is loading.
module arcade_rom_loader
  import arcade_pkg::*;
#(
  parameter int ROM_BYTES   = 98304,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 18
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ioctl_download,
  input  logic             ioctl_wr,
  input  logic [24:0]      ioctl_addr,
  input  logic [7:0]       ioctl_dout,
  input  logic [7:0]       ioctl_index,
  output logic [16:0]      dn_addr,
  output logic [7:0]       dn_data,
  output logic             dn_wr,
  output logic [7:0]       dsw_a,
  output logic [7:0]       dsw_b,
  output logic             rom_busy,
  output logic             rom_loaded,
  output logic             rom_error,
  output logic [CNT_W-1:0] byte_count
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  loader_state_t    state_r, next_state_s;
  logic             enter_load_s, accept_s, drop_s, fall_s;
  logic             in_range_s, timer_done_s, size_bad_s, dip_hit_s;
  logic             block_r;
  logic [CNT_W-1:0] count_inc_s, count_next_s;
  logic [16:0]      dn_addr_r;
  logic [7:0]       dn_data_r, dsw_a_r, dsw_b_r;
  logic             dn_wr_r, rom_busy_r, rom_loaded_r, rom_error_r;
  logic [CNT_W-1:0] byte_count_r;

  assign in_range_s   = (ioctl_addr < 25'(ROM_BYTES));
  assign count_inc_s  = (byte_count_r == '1) ? byte_count_r : byte_count_r + CNT_W'(1);
  assign count_next_s = accept_s ? count_inc_s : byte_count_r;
  assign size_bad_s   = (count_next_s != CNT_W'(ROM_BYTES));
  assign dip_hit_s    = ioctl_wr && (ioctl_index == IDX_DSW) && (ioctl_addr[24:1] == 24'd0);

  hold_timer #(.W(HW)) u_hold_timer (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .start    (fall_s),
    .load_val (HW'(HOLD_CYCLES - 1)),
    .done     (timer_done_s)
  );

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // Next-state and per-cycle load decisions.
  always_comb begin
    next_state_s = state_r;
    enter_load_s = 1'b0;
    accept_s     = 1'b0;
    drop_s       = 1'b0;
    fall_s       = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (ioctl_download && (ioctl_index == IDX_ROM) && !block_r) begin
          next_state_s = LOAD;
          enter_load_s = 1'b1;
        end else begin
          next_state_s = state_r;
        end
      end
      LOAD: begin
        // A byte arriving alongside the download drop is still taken.
        if (ioctl_wr) begin
          accept_s = in_range_s;
          drop_s   = !in_range_s;
        end else begin
          accept_s = 1'b0;
          drop_s   = 1'b0;
        end
        if (!ioctl_download) begin
          next_state_s = HOLD;
          fall_s       = 1'b1;
        end else begin
          next_state_s = LOAD;
        end
      end
      HOLD: begin
        if (timer_done_s) next_state_s = DONE;
        else              next_state_s = HOLD;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // ROM write path, byte counter and load status.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dn_addr_r    <= 17'd0;
      dn_data_r    <= 8'd0;
      dn_wr_r      <= 1'b0;
      rom_busy_r   <= 1'b0;
      rom_loaded_r <= 1'b0;
      rom_error_r  <= 1'b0;
      byte_count_r <= '0;
      block_r      <= 1'b1;
    end else begin
      // A download already in progress at reset must drop before it can start a load.
      block_r <= block_r & ioctl_download;
      dn_wr_r <= accept_s;
      if (accept_s) begin
        dn_addr_r <= ioctl_addr[16:0];
        dn_data_r <= ioctl_dout;
      end
      if (enter_load_s) begin
        byte_count_r <= '0;
        rom_error_r  <= 1'b0;
        rom_loaded_r <= 1'b0;
        rom_busy_r   <= 1'b1;
      end else begin
        byte_count_r <= count_next_s;
        if (drop_s || (fall_s && size_bad_s)) rom_error_r <= 1'b1;
        if ((state_r == HOLD) && timer_done_s) begin
          rom_busy_r   <= 1'b0;
          rom_loaded_r <= ~rom_error_r;
        end
      end
    end
  end

  // DIP capture runs in every state.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dsw_a_r <= 8'hFF;
      dsw_b_r <= 8'hFF;
    end else if (dip_hit_s) begin
      if (ioctl_addr[0]) dsw_b_r <= ~ioctl_dout;
      else               dsw_a_r <= ~ioctl_dout;
    end
  end

  assign dn_addr    = dn_addr_r;
  assign dn_data    = dn_data_r;
  assign dn_wr      = dn_wr_r;
  assign dsw_a      = dsw_a_r;
  assign dsw_b      = dsw_b_r;
  assign rom_busy   = rom_busy_r;
  assign rom_loaded = rom_loaded_r;
  assign rom_error  = rom_error_r;
  assign byte_count = byte_count_r;

endmodule

// File: tb/tb_arcade_rom_loader.sv
// Directed bench for arcade_rom_loader; a reduced ROM size keeps the run short.
module tb_arcade_rom_loader;

  localparam int ROM  = 1024;
  localparam int HOLD = 16;
  localparam int CW   = 18;

  logic          clk_sys = 1'b0;
  logic          reset, ioctl_download, ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout, ioctl_index;
  logic [16:0]   dn_addr;
  logic [7:0]    dn_data, dsw_a, dsw_b;
  logic          dn_wr, rom_busy, rom_loaded, rom_error;
  logic [CW-1:0] byte_count;

  int checks   = 0;
  int failures = 0;

  arcade_rom_loader #(.ROM_BYTES(ROM), .HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .dsw_a          (dsw_a),
    .dsw_b          (dsw_b),
    .rom_busy       (rom_busy),
    .rom_loaded     (rom_loaded),
    .rom_error      (rom_error),
    .byte_count     (byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // One ROM byte; the write must appear exactly one cycle later.
  task automatic wr_rom(input int a, input logic [7:0] d, input int gap);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    step();
    ioctl_wr = 1'b0;
    check_eq("dn_beat", {dn_wr, dn_addr, dn_data}, {1'b1, 17'(a), d});
    if (gap > 1) begin
      step();
      check_eq("dn_pulse", dn_wr, 32'd0);
      for (int g = 2; g < gap; g++) step();
    end
  endtask

  task automatic wr_dip(input int a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    step();
    ioctl_wr = 1'b0;
  endtask

  // Number of post-edge samples with rom_busy still high, bounded.
  task automatic wait_hold(output int n);
    n = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      if (rom_busy) n++;
      else break;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = 25'd0; ioctl_dout = 8'd0; ioctl_index = 8'd0;
    step(); step();
    reset = 1'b0;
    step();
    check_eq("rst_dn", {dn_wr, dn_addr, dn_data}, 32'd0);
    check_eq("rst_dsw", {dsw_a, dsw_b}, 32'hFFFF);
    check_eq("rst_status", {rom_busy, rom_loaded, rom_error}, 32'd0);
    check_eq("rst_count", byte_count, 32'd0);

    // Full load, one byte every 4 cycles
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    step();
    check_eq("busy_entry", rom_busy, 32'd1);
    for (int a = 0; a < ROM; a++) wr_rom(a, 8'(a * 7 + 3), 4);
    check_eq("count_full", byte_count, ROM);
    ioctl_download = 1'b0;
    wait_hold(n);
    check_eq("hold_full", n, HOLD);
    check_eq("loaded_full", rom_loaded, 32'd1);
    check_eq("err_full", rom_error, 32'd0);

    // DIP bank capture
    ioctl_index = 8'd254; ioctl_download = 1'b1;
    wr_dip(0, 8'h3C);
    check_eq("dsw_a", dsw_a, 32'hC3);
    check_eq("dip_no_dn", dn_wr, 32'd0);
    wr_dip(1, 8'h0F);
    check_eq("dsw_b", dsw_b, 32'hF0);
    check_eq("dsw_a_keep", dsw_a, 32'hC3);
    wr_dip(2, 8'h55);
    check_eq("dsw_addr2", {dsw_a, dsw_b}, 32'hC3F0);
    ioctl_download = 1'b0;
    step();
    check_eq("dip_no_busy", rom_busy, 32'd0);
    check_eq("dip_loaded", rom_loaded, 32'd1);

    // Foreign index is ignored
    ioctl_index = 8'd7; ioctl_download = 1'b1;
    step();
    ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_dout = 8'h99;
    step();
    ioctl_wr = 1'b0;
    check_eq("idx7_dn", dn_wr, 32'd0);
    check_eq("idx7_busy", rom_busy, 32'd0);
    check_eq("idx7_count", byte_count, ROM);
    ioctl_download = 1'b0;
    step();

    // Overflow write
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    step();
    check_eq("loaded_clr", rom_loaded, 32'd0);
    wr_rom(0, 8'h11, 1);
    ioctl_wr = 1'b1; ioctl_addr = 25'(ROM); ioctl_dout = 8'hA5;
    step();
    ioctl_wr = 1'b0;
    check_eq("ovf_dn", dn_wr, 32'd0);
    check_eq("ovf_err", rom_error, 32'd1);
    check_eq("ovf_count", byte_count, 32'd1);
    ioctl_download = 1'b0;
    wait_hold(n);
    check_eq("hold_ovf", n, HOLD);
    check_eq("ovf_status", {rom_loaded, rom_error}, 32'b01);

    // Short load
    ioctl_download = 1'b1;
    step();
    check_eq("err_clr", rom_error, 32'd0);
    for (int a = 0; a < ROM - 1; a++) wr_rom(a, 8'(a ^ 8'h5A), 2);
    ioctl_download = 1'b0;
    wait_hold(n);
    check_eq("hold_short", n, HOLD);
    check_eq("short_status", {rom_loaded, rom_error}, 32'b01);
    check_eq("short_count", byte_count, ROM - 1);

    // Back-to-back tail, last byte in the same cycle as the download drop
    ioctl_download = 1'b1;
    step();
    for (int a = 0; a < ROM - 8; a++) wr_rom(a, 8'(a + 1), 2);
    for (int i = 0; i < 8; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(ROM - 8 + i); ioctl_dout = 8'(8'hC0 + i);
      if (i == 7) ioctl_download = 1'b0;
      step();
      check_eq("b2b_beat", {dn_wr, dn_addr, dn_data}, {1'b1, 17'(ROM - 8 + i), 8'(8'hC0 + i)});
    end
    ioctl_wr = 1'b0;
    wait_hold(n);
    check_eq("hold_b2b", n, HOLD - 1);
    check_eq("b2b_status", {rom_loaded, rom_error}, 32'b10);
    check_eq("b2b_count", byte_count, ROM);

    // Reset in the middle of HOLD, with the download line left high
    ioctl_download = 1'b1;
    step();
    for (int a = 0; a < 3; a++) wr_rom(a, 8'(a), 1);
    ioctl_download = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check_eq("busy_mid_hold", rom_busy, 32'd1);
    reset = 1'b1; ioctl_download = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rst_hold_busy", rom_busy, 32'd0);
    check_eq("rst_hold_dsw", {dsw_a, dsw_b}, 32'hFFFF);
    check_eq("rst_hold_count", byte_count, 32'd0);
    check_eq("rst_hold_status", {rom_loaded, rom_error}, 32'd0);
    ioctl_wr = 1'b1; ioctl_addr = 25'd5; ioctl_dout = 8'h77;
    step();
    ioctl_wr = 1'b0;
    check_eq("stray_dn", dn_wr, 32'd0);
    check_eq("stray_busy", rom_busy, 32'd0);
    ioctl_download = 1'b0;
    step();
    ioctl_download = 1'b1;
    step();
    check_eq("busy_fresh", rom_busy, 32'd1);
    ioctl_download = 1'b0;
    wait_hold(n);
    check_eq("hold_empty", n, HOLD);
    check_eq("empty_status", {rom_loaded, rom_error}, 32'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
